// File: rtl/solver_pkg.sv
// Shared definitions for the generation solver: FSM encodings, edge topology
// constants and the width/rule helpers used by gen_solver and row_stepper.
package solver_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_LAST = 3'd1;
  localparam logic [2:0] ST_RD_0    = 3'd2;
  localparam logic [2:0] ST_RD_1    = 3'd3;
  localparam logic [2:0] ST_WR_CUR  = 3'd4;
  localparam logic [2:0] ST_RD_NEXT = 3'd5;

  localparam logic EDGE_TORUS = 1'b0;
  localparam logic EDGE_DEAD  = 1'b1;

  function automatic int pop_width(input int width, input int height);
    return $clog2(width * height + 1);
  endfunction

  // Life kernel: bit 1 of mid is the cell itself, the other eight bits are its neighbours.
  function automatic logic life_rule(input logic [2:0] top, input logic [2:0] mid,
                                     input logic [2:0] bot);
    int n;
    n = int'(top[0]) + int'(top[1]) + int'(top[2]) + int'(mid[0]) + int'(mid[2]) +
        int'(bot[0]) + int'(bot[1]) + int'(bot[2]);
    return (n == 3) || (mid[1] && (n == 2));
  endfunction

endpackage

// File: rtl/row_stepper.sv
// Combinational next-generation computation for one row from its three-row window,
// with column wrap (torus) or zero padding (dead edges) at the row ends.
module row_stepper
  import solver_pkg::*;
#(
  parameter int ARENA_WIDTH = 10
) (
  input  logic                   edge_mode,
  input  logic [ARENA_WIDTH-1:0] prev_row,
  input  logic [ARENA_WIDTH-1:0] cur_row,
  input  logic [ARENA_WIDTH-1:0] next_row,
  output logic [ARENA_WIDTH-1:0] new_row
);

  logic                   dead;
  logic [ARENA_WIDTH+1:0] prev_ext;
  logic [ARENA_WIDTH+1:0] cur_ext;
  logic [ARENA_WIDTH+1:0] next_ext;

  // Each row gains a pad column on both sides so every cell sees a uniform 3-wide window.
  function automatic logic [ARENA_WIDTH+1:0] extend(input logic [ARENA_WIDTH-1:0] row,
                                                    input logic pad_zero);
    return {pad_zero ? 1'b0 : row[0], row, pad_zero ? 1'b0 : row[ARENA_WIDTH-1]};
  endfunction

  assign dead     = (edge_mode == EDGE_DEAD);
  assign prev_ext = extend(prev_row, dead);
  assign cur_ext  = extend(cur_row, dead);
  assign next_ext = extend(next_row, dead);

  for (genvar c = 0; c < ARENA_WIDTH; c++) begin : g_cell
    assign new_row[c] = life_rule(prev_ext[c+2:c], cur_ext[c+2:c], next_ext[c+2:c]);
  end

endmodule

// File: rtl/gen_solver.sv
// Multi-generation Game-of-Life engine updating the arena row memory in place.
// Optional live-cell count output enabled by defining SOLVER_POPCOUNT_EN.
module gen_solver
  import solver_pkg::*;
#(
  parameter int ARENA_WIDTH  = 10,
  parameter int ARENA_HEIGHT = 10,
  parameter int ROW_ADDR_W   = 8,
  parameter int GEN_W        = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [GEN_W-1:0]       generations_count,
  input  logic                   edge_mode,
  input  logic                   stop_on_stable,
  input  logic                   abort,
  output logic                   ready,
  output logic                   done,
  output logic                   stable,
  output logic [GEN_W-1:0]       gens_completed,
  output logic [ROW_ADDR_W-1:0]  arena_row_select,
  input  logic [ARENA_WIDTH-1:0] arena_columns,
  output logic [ARENA_WIDTH-1:0] arena_columns_new,
  output logic                   arena_columns_write
`ifdef SOLVER_POPCOUNT_EN
  ,
  output logic [solver_pkg::pop_width(ARENA_WIDTH, ARENA_HEIGHT)-1:0] population
`endif
);

  localparam logic [ROW_ADDR_W-1:0] LAST_ROW = ROW_ADDR_W'(ARENA_HEIGHT - 1);

  logic [2:0]             state;
  logic [ROW_ADDR_W-1:0]  cur_idx;
  logic [GEN_W-1:0]       remaining;
  logic [GEN_W-1:0]       gens_q;
  logic                   edge_q;
  logic                   stop_q;
  logic                   abort_seen;
  logic                   changed;
  logic                   done_q;
  logic                   stable_q;
  logic [ARENA_WIDTH-1:0] prev_row;
  logic [ARENA_WIDTH-1:0] cur_row;
  logic [ARENA_WIDTH-1:0] next_row;
  logic [ARENA_WIDTH-1:0] row0_saved;
  logic [ARENA_WIDTH-1:0] new_row;

  logic gen_last;
  logic row_changed;
  logic settled;
  logic finish;

`ifdef SOLVER_POPCOUNT_EN
  localparam int POP_W = pop_width(ARENA_WIDTH, ARENA_HEIGHT);
  logic [POP_W-1:0] pop_acc;
  logic [POP_W-1:0] pop_row;
  logic [POP_W-1:0] population_q;

  assign pop_row    = POP_W'($countones(new_row));
  assign population = population_q;
`endif

  row_stepper #(.ARENA_WIDTH(ARENA_WIDTH)) u_stepper (
    .edge_mode (edge_q),
    .prev_row  (prev_row),
    .cur_row   (cur_row),
    .next_row  (next_row),
    .new_row   (new_row)
  );

  assign ready               = (state == ST_IDLE);
  assign done                = done_q;
  assign stable              = stable_q;
  assign gens_completed      = gens_q;
  assign arena_columns_new   = new_row;
  assign arena_columns_write = (state == ST_WR_CUR);

  assign gen_last    = (cur_idx == LAST_ROW);
  assign row_changed = (new_row != cur_row);
  assign settled     = stop_q && !(changed || row_changed);
  assign finish      = (remaining == GEN_W'(1)) || abort_seen || abort || settled;

  always_comb begin
    arena_row_select = '0;
    case (state)
      ST_RD_LAST: arena_row_select = LAST_ROW;
      ST_RD_1:    arena_row_select = ROW_ADDR_W'(1);
      ST_WR_CUR:  arena_row_select = cur_idx;
      ST_RD_NEXT: if (!gen_last) arena_row_select = cur_idx + 1'b1;
      default:    arena_row_select = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cur_idx    <= '0;
      remaining  <= '0;
      gens_q     <= '0;
      edge_q     <= EDGE_TORUS;
      stop_q     <= 1'b0;
      abort_seen <= 1'b0;
      changed    <= 1'b0;
      done_q     <= 1'b0;
      stable_q   <= 1'b0;
      prev_row   <= '0;
      cur_row    <= '0;
      next_row   <= '0;
      row0_saved <= '0;
`ifdef SOLVER_POPCOUNT_EN
      pop_acc      <= '0;
      population_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      if (state != ST_IDLE && abort) abort_seen <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (generations_count != '0) begin
              remaining  <= generations_count;
              edge_q     <= edge_mode;
              stop_q     <= stop_on_stable;
              stable_q   <= 1'b0;
              gens_q     <= '0;
              cur_idx    <= '0;
              abort_seen <= 1'b0;
              changed    <= 1'b0;
`ifdef SOLVER_POPCOUNT_EN
              pop_acc    <= '0;
`endif
              state      <= ST_RD_LAST;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        ST_RD_LAST: begin
          prev_row <= (edge_q == EDGE_DEAD) ? '0 : arena_columns;
          state    <= ST_RD_0;
        end
        ST_RD_0: begin
          cur_row    <= arena_columns;
          row0_saved <= arena_columns;
          state      <= ST_RD_1;
        end
        ST_RD_1: begin
          next_row <= arena_columns;
          state    <= ST_WR_CUR;
        end
        ST_WR_CUR: begin
          prev_row <= cur_row;
          cur_row  <= next_row;
          if (!gen_last) begin
            if (row_changed) changed <= 1'b1;
`ifdef SOLVER_POPCOUNT_EN
            pop_acc <= pop_acc + pop_row;
`endif
            cur_idx <= cur_idx + 1'b1;
            state   <= ST_RD_NEXT;
          end else begin
            // Generation boundary: the arena is consistent, so this is the only exit point.
            if (gens_q != '1) gens_q <= gens_q + 1'b1;
            remaining  <= remaining - 1'b1;
            cur_idx    <= '0;
            changed    <= 1'b0;
            abort_seen <= 1'b0;
`ifdef SOLVER_POPCOUNT_EN
            population_q <= pop_acc + pop_row;
            pop_acc      <= '0;
`endif
            if (finish) begin
              stable_q <= settled;
              done_q   <= 1'b1;
              state    <= ST_IDLE;
            end else begin
              state <= ST_RD_LAST;
            end
          end
        end
        ST_RD_NEXT: begin
          // Row 0 is already overwritten when the last row needs it as bottom neighbour.
          if (gen_last) next_row <= (edge_q == EDGE_DEAD) ? '0 : row0_saved;
          else          next_row <= arena_columns;
          state <= ST_WR_CUR;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gen_solver.sv
// Directed self-checking bench for gen_solver on a 5x5 arena backed by a behavioural row memory.
module tb_gen_solver;

  localparam int W  = 5;
  localparam int H  = 5;
  localparam int AW = 3;
  localparam int GW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [GW-1:0] generations_count;
  logic          edge_mode;
  logic          stop_on_stable;
  logic          abort;
  logic          ready;
  logic          done;
  logic          stable;
  logic [GW-1:0] gens_completed;
  logic [AW-1:0] arena_row_select;
  logic [W-1:0]  arena_columns;
  logic [W-1:0]  arena_columns_new;
  logic          arena_columns_write;
`ifdef SOLVER_POPCOUNT_EN
  logic [4:0]    population;
`endif

  logic [W-1:0] arena [H];
  logic [W-1:0] load_rows [H];
  logic         load_req = 1'b0;
  int           write_count = 0;
  int           checks = 0;
  int           failures = 0;

  always #5 clk = ~clk;

  gen_solver #(
    .ARENA_WIDTH(W), .ARENA_HEIGHT(H), .ROW_ADDR_W(AW), .GEN_W(GW)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .start               (start),
    .generations_count   (generations_count),
    .edge_mode           (edge_mode),
    .stop_on_stable      (stop_on_stable),
    .abort               (abort),
    .ready               (ready),
    .done                (done),
    .stable              (stable),
    .gens_completed      (gens_completed),
    .arena_row_select    (arena_row_select),
    .arena_columns       (arena_columns),
    .arena_columns_new   (arena_columns_new),
    .arena_columns_write (arena_columns_write)
`ifdef SOLVER_POPCOUNT_EN
    ,
    .population          (population)
`endif
  );

  // Asynchronous-read row memory; bit c of a row is column c.
  always_comb begin
    arena_columns = '0;
    for (int i = 0; i < H; i++)
      if (int'(arena_row_select) == i) arena_columns = arena[i];
  end

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < H; i++) arena[i] <= load_rows[i];
    end else if (arena_columns_write) begin
      for (int i = 0; i < H; i++)
        if (int'(arena_row_select) == i) arena[i] <= arena_columns_new;
      write_count <= write_count + 1;
    end
  end

  task automatic load_arena(input logic [W-1:0] r0, r1, r2, r3, r4);
    load_rows[0] = r0; load_rows[1] = r1; load_rows[2] = r2;
    load_rows[3] = r3; load_rows[4] = r4;
    @(negedge clk) load_req = 1'b1;
    @(negedge clk) load_req = 1'b0;
  endtask

  // Starts a run and counts cycles from the start edge until done; abort pulses at abort_at.
  task automatic run_solver(input logic [GW-1:0] count, input logic em, input logic sos,
                            input int abort_at, output int cycles, output int writes);
    int w0;
    w0 = write_count;
    @(negedge clk);
    generations_count = count; edge_mode = em; stop_on_stable = sos; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    while (!done && cycles < 2000) begin
      abort = (cycles == abort_at);
      @(negedge clk);
      cycles++;
    end
    abort = 1'b0;
    if (!done) begin
      failures++;
      $display("[TB] FAIL run_timeout: no done after %0d cycles, required done=1", cycles);
    end
    writes = write_count - w0;
  endtask

  task automatic test_reset();
    checks++;
    if (ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready: got %b required 1", ready); end
    checks++;
    if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b required 0", done); end
    checks++;
    if (stable !== 1'b0) begin failures++; $display("[TB] FAIL reset_stable: got %b required 0", stable); end
    checks++;
    if (gens_completed !== '0) begin failures++; $display("[TB] FAIL reset_gens: got %0d required 0", gens_completed); end
    checks++;
    if (arena_columns_write !== 1'b0) begin failures++; $display("[TB] FAIL reset_write: got %b required 0", arena_columns_write); end
`ifdef SOLVER_POPCOUNT_EN
    checks++;
    if (population !== '0) begin failures++; $display("[TB] FAIL reset_population: got %0d required 0", population); end
`endif
  endtask

  task automatic test_blinker_one();
    int cycles, writes;
    logic [W-1:0] exp_rows [H];
    exp_rows = '{5'b00000, 5'b00000, 5'b01110, 5'b00000, 5'b00000};
    load_arena(5'b00000, 5'b00100, 5'b00100, 5'b00100, 5'b00000);
    run_solver(32'd1, 1'b0, 1'b0, -1, cycles, writes);
    checks++;
    if (cycles !== 12) begin failures++; $display("[TB] FAIL blinker1_latency: got %0d required 12", cycles); end
    checks++;
    if (writes !== 5) begin failures++; $display("[TB] FAIL blinker1_writes: got %0d required 5", writes); end
    checks++;
    if (gens_completed !== 32'd1) begin failures++; $display("[TB] FAIL blinker1_gens: got %0d required 1", gens_completed); end
    checks++;
    if (ready !== 1'b1) begin failures++; $display("[TB] FAIL blinker1_ready: got %b required 1", ready); end
    for (int i = 0; i < H; i++) begin
      checks++;
      if (arena[i] !== exp_rows[i]) begin failures++; $display("[TB] FAIL blinker1_row%0d: got %b required %b", i, arena[i], exp_rows[i]); end
    end
`ifdef SOLVER_POPCOUNT_EN
    checks++;
    if (population !== 5'd3) begin failures++; $display("[TB] FAIL blinker1_population: got %0d required 3", population); end
`endif
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin failures++; $display("[TB] FAIL blinker1_done_pulse: got %b required 0", done); end
  endtask

  task automatic test_blinker_two();
    int cycles, writes;
    logic [W-1:0] exp_rows [H];
    exp_rows = '{5'b00000, 5'b00100, 5'b00100, 5'b00100, 5'b00000};
    load_arena(5'b00000, 5'b00100, 5'b00100, 5'b00100, 5'b00000);
    run_solver(32'd2, 1'b0, 1'b0, -1, cycles, writes);
    checks++;
    if (cycles !== 24) begin failures++; $display("[TB] FAIL blinker2_latency: got %0d required 24", cycles); end
    checks++;
    if (gens_completed !== 32'd2) begin failures++; $display("[TB] FAIL blinker2_gens: got %0d required 2", gens_completed); end
    for (int i = 0; i < H; i++) begin
      checks++;
      if (arena[i] !== exp_rows[i]) begin failures++; $display("[TB] FAIL blinker2_row%0d: got %b required %b", i, arena[i], exp_rows[i]); end
    end
  endtask

  task automatic test_still_life();
    int cycles, writes;
    load_arena(5'b00000, 5'b00110, 5'b00110, 5'b00000, 5'b00000);
    run_solver(32'd100, 1'b0, 1'b1, -1, cycles, writes);
    checks++;
    if (cycles !== 12) begin failures++; $display("[TB] FAIL still_latency: got %0d required 12", cycles); end
    checks++;
    if (stable !== 1'b1) begin failures++; $display("[TB] FAIL still_stable: got %b required 1", stable); end
    checks++;
    if (gens_completed !== 32'd1) begin failures++; $display("[TB] FAIL still_gens: got %0d required 1", gens_completed); end
    checks++;
    if (arena[1] !== 5'b00110 || arena[2] !== 5'b00110) begin
      failures++; $display("[TB] FAIL still_rows: got %b/%b required 00110/00110", arena[1], arena[2]);
    end
  endtask

  task automatic test_glider_torus();
    int cycles, writes;
    logic [W-1:0] exp_rows [H];
    exp_rows = '{5'b11001, 5'b00000, 5'b00000, 5'b10000, 5'b00001};
    load_arena(5'b00000, 5'b00000, 5'b01000, 5'b10000, 5'b11100);
    run_solver(32'd4, 1'b0, 1'b0, -1, cycles, writes);
    checks++;
    if (cycles !== 48) begin failures++; $display("[TB] FAIL glider_torus_latency: got %0d required 48", cycles); end
    checks++;
    if (stable !== 1'b0) begin failures++; $display("[TB] FAIL glider_torus_stable: got %b required 0", stable); end
    for (int i = 0; i < H; i++) begin
      checks++;
      if (arena[i] !== exp_rows[i]) begin failures++; $display("[TB] FAIL glider_torus_row%0d: got %b required %b", i, arena[i], exp_rows[i]); end
    end
  endtask

  task automatic test_glider_dead();
    int cycles, writes;
    logic [W-1:0] exp_rows [H];
    exp_rows = '{5'b00000, 5'b00000, 5'b00000, 5'b11000, 5'b11000};
    load_arena(5'b00000, 5'b00000, 5'b01000, 5'b10000, 5'b11100);
    run_solver(32'd4, 1'b1, 1'b0, -1, cycles, writes);
    checks++;
    if (gens_completed !== 32'd4) begin failures++; $display("[TB] FAIL glider_dead_gens: got %0d required 4", gens_completed); end
    for (int i = 0; i < H; i++) begin
      checks++;
      if (arena[i] !== exp_rows[i]) begin failures++; $display("[TB] FAIL glider_dead_row%0d: got %b required %b", i, arena[i], exp_rows[i]); end
    end
  endtask

  task automatic test_abort();
    int cycles, writes;
    load_arena(5'b00000, 5'b00100, 5'b00100, 5'b00100, 5'b00000);
    run_solver(32'd10, 1'b0, 1'b0, 30, cycles, writes);
    checks++;
    if (cycles !== 36) begin failures++; $display("[TB] FAIL abort_latency: got %0d required 36", cycles); end
    checks++;
    if (gens_completed !== 32'd3) begin failures++; $display("[TB] FAIL abort_gens: got %0d required 3", gens_completed); end
    checks++;
    if (writes !== 15) begin failures++; $display("[TB] FAIL abort_writes: got %0d required 15", writes); end
    checks++;
    if (arena[2] !== 5'b01110 || arena[1] !== 5'b00000) begin
      failures++; $display("[TB] FAIL abort_rows: got %b/%b required 00000/01110", arena[1], arena[2]);
    end
  endtask

  task automatic test_zero_count();
    int cycles, writes;
    run_solver(32'd0, 1'b0, 1'b0, -1, cycles, writes);
    checks++;
    if (cycles !== 0) begin failures++; $display("[TB] FAIL zero_latency: got %0d required 0", cycles); end
    checks++;
    if (writes !== 0) begin failures++; $display("[TB] FAIL zero_writes: got %0d required 0", writes); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || ready !== 1'b1) begin
      failures++; $display("[TB] FAIL zero_after: got done=%b ready=%b required done=0 ready=1", done, ready);
    end
  endtask

  task automatic test_reset_mid_run();
    load_arena(5'b00000, 5'b00100, 5'b00100, 5'b00100, 5'b00000);
    @(negedge clk);
    generations_count = 32'd10; edge_mode = 1'b0; stop_on_stable = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    checks++;
    if (gens_completed !== 32'd1 || ready !== 1'b0) begin
      failures++; $display("[TB] FAIL midrun_progress: got gens=%0d ready=%b required gens=1 ready=0", gens_completed, ready);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b1 || done !== 1'b0 || stable !== 1'b0 || gens_completed !== '0 || arena_columns_write !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midrun_reset: got ready=%b done=%b stable=%b gens=%0d write=%b required 1 0 0 0 0",
               ready, done, stable, gens_completed, arena_columns_write);
    end
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; generations_count = '0; edge_mode = 1'b0;
    stop_on_stable = 1'b0; abort = 1'b0;
    for (int i = 0; i < H; i++) load_rows[i] = '0;
    repeat (2) @(negedge clk);
    test_reset();
    reset_n = 1'b1;
    @(negedge clk);
    test_blinker_one();
    test_blinker_two();
    test_still_life();
    test_glider_torus();
    test_glider_dead();
    test_abort();
    test_zero_count();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
